bls_serial_sub: RTL and testbench
=================================

# bls_serial_sub

Multi-cycle WIDTH-bit subtractor that computes D = A − B − bin one 4-bit nibble per clock. A borrow register chains the borrow-out of each nibble into the next, least-significant nibble first. It sits in the datapath as the sequencing stage that feeds the team's 4-bit borrow-lookahead slice, so wide operands reuse a single nibble-wide subtractor. Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, ≥ 4. N = WIDTH/4 nibbles.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b, bin valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in to nibble 0.
- out_valid  out  1  d, bout (and ovf) valid.
- out_ready  in  1  consumer accepts result.
- d  out  WIDTH  difference, (a − b − bin) mod 2^WIDTH.
- bout  out  1  final borrow-out; 1 iff a < b + bin (unsigned).
- ovf  out  1  signed overflow; present only with SUB_OVERFLOW_EN.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at the edge: latch a and b, set borrow=bin, set nibble index k=0, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge, nibble k is computed from the latched operands: d[4k+3:4k] = (a_k − b_k − borrow) mod 16, and borrow = 1 iff a_k < b_k + borrow. Then k = k+1.
  - After nibble N−1 is processed, bout = borrow and the FSM goes to DONE.
- DONE:
  - out_valid=1, in_ready=0. d, bout and ovf are held stable.
  - On out_ready at the edge: go to IDLE and drop out_valid.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- d is written nibble by nibble during RUN. Its value is only defined when out_valid=1.
- Index k is ceil(log2 N) bits wide. k never wraps past N−1; leaving RUN resets it.
- Reset values: in_ready=0 while rst is high and 1 from the first cycle after release; out_valid=0, d=0, bout=0, ovf=0, borrow=0, k=0.
- Reset mid-operation (RUN or DONE): abort immediately. The result is discarded and no out_valid pulse is produced.

## Timing
- Accept edge E0: in_valid & in_ready sampled high.
- Nibble k is written at edge E(k+1).
- out_valid rises after edge EN, i.e. N cycles after acceptance (4 for WIDTH=16).
- Minimum spacing between accepts is N+2 edges, when out_ready is held high. The path is DONE→IDLE, with the new accept in IDLE.
- Backpressure: out_valid stays high and the outputs stay frozen indefinitely until out_ready.
- Combinational path: in_ready and out_valid are pure functions of state. There is no combinational path from in_valid or out_ready to any output.
- Critical path is one 4-bit subtract plus the borrow mux, independent of WIDTH.

## Configuration
- SUB_OVERFLOW_EN, defined:
  - ovf port exists.
  - At the transition to DONE, ovf = (a[WIDTH−1] ≠ b[WIDTH−1]) & (d[WIDTH−1] ≠ a[WIDTH−1]), using the latched a and b.
  - ovf is held with d and reset to 0.
- SUB_OVERFLOW_EN, undefined: no ovf port, no ovf logic. All other behaviour is identical.

## Test plan
- Basic: WIDTH=16, a=0x1234, b=0x0234, bin=0, out_ready=1.
  - out_valid rises 4 cycles after accept; d=0x1000, bout=0; ovf=0 when enabled.
- Full borrow ripple: a=0x0000, b=0x0001, bin=0.
  - d=0xFFFF, bout=1. Then a=0x0005, b=0x0005, bin=1: d=0xFFFF, bout=1.
- Signed overflow (macro on): a=0x8000, b=0x0001, bin=0.
  - d=0x7FFF, bout=0, ovf=1. Then a=0x7FFF, b=0xFFFF: d=0x8000, bout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_valid, d and bout stay constant and in_ready stays 0.
  - After out_ready=1 for one edge: out_valid=0 and in_ready=1 on the next cycle.
- Ignored input: pulse in_valid with different operands during RUN and DONE.
  - Result is unchanged and matches the originally accepted operands.
- Reset mid-operation: assert rst for one cycle at edge E2.
  - Next cycle: out_valid=0, d=0, bout=0, state IDLE.
  - A fresh transaction a=0xFFFF, b=0x0001 then yields d=0xFFFE, bout=0.

Source files
------------

// File: rtl/bls_serial_sub.sv
// bls_serial_sub: serial WIDTH-bit subtractor, D = A - B - bin, one 4-bit nibble per clock, LSB nibble first.
// Latency: out_valid rises N = WIDTH/4 cycles after the accept edge. Minimum accept spacing is N+2 edges.
// Backpressure: DONE holds d/bout/ovf frozen until out_ready. in_ready is low outside IDLE.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with a, b, bin; out_valid/out_ready with d, bout[, ovf].
// Optional feature macro: SUB_OVERFLOW_EN adds the ovf port, the signed-overflow flag for the full-width result.
module bls_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
 ,output logic             ovf
`endif
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [KW-1:0]    k;
  logic [4:0]       nib_diff;

`ifdef SUB_OVERFLOW_EN
  // Operand sign bits are kept aside because the operand registers are
  // shifted away while the nibbles are consumed.
  logic a_sign;
  logic b_sign;
`endif

  // Operands shift right so the active nibble is always in bits [3:0];
  // this keeps the datapath a single 4-bit subtract regardless of WIDTH.
  // Bit 4 of the 5-bit difference is the nibble borrow-out.
  assign nib_diff = {1'b0, a_sh[3:0]} - {1'b0, b_sh[3:0]} - {4'b0000, borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      d         <= '0;
      bout      <= 1'b0;
      borrow    <= 1'b0;
      k         <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
`ifdef SUB_OVERFLOW_EN
      ovf       <= 1'b0;
      a_sign    <= 1'b0;
      b_sign    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // in_ready is registered, so it comes up on the first edge after reset release.
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            a_sh     <= a;
            b_sh     <= b;
            borrow   <= bin;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
`ifdef SUB_OVERFLOW_EN
            a_sign   <= a[WIDTH-1];
            b_sign   <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 4;
          b_sh   <= b_sh >> 4;
          // Each result nibble enters at the top; after N shifts nibble 0
          // has reached bits [3:0].
          d      <= (d >> 4) | (WIDTH'(nib_diff[3:0]) << (WIDTH - 4));
          borrow <= nib_diff[4];
          if (k == K_LAST) begin
            k         <= '0;
            bout      <= nib_diff[4];
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SUB_OVERFLOW_EN
            // nib_diff[3] is the final result's sign bit.
            ovf       <= (a_sign != b_sign) && (nib_diff[3] != a_sign);
`endif
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bls_serial_sub.sv
// tb_bls_serial_sub: directed bench for bls_serial_sub (WIDTH=16) with a result scoreboard.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
// Summary line: CHECKS <n> ERRORS <n>.
module tb_bls_serial_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         bout;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  typedef struct {
    logic [W:0] val;  // {bout, d}
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bls_serial_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
`ifdef SUB_OVERFLOW_EN
   ,.ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: accept, wait for the result with a cycle budget,
  // optionally stall the output and/or wiggle in_valid while busy.
  task automatic run_txn(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tbin, input int hold, input bit junk);
    exp_t e;
    exp_t got;
    int   lat;
    e.val = {1'b0, ta} - {1'b0, tb_v} - {{W{1'b0}}, tbin};
    e.ovf = (ta[W-1] != tb_v[W-1]) && (e.val[W-1] != ta[W-1]);
    check({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    tick();  // accept edge E0
    sb.push_back(e);
    in_valid = 1'b0;
    if (junk) begin
      a = ~ta; b = 16'h1357; bin = ~tbin; in_valid = 1'b1;
    end
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 50);
    check({tag, ".latency"}, 32'(lat), 32'd4);
    got = sb.pop_front();
    check({tag, ".d"}, 32'(d), 32'(got.val[W-1:0]));
    check({tag, ".bout"}, 32'(bout), 32'(got.val[W]));
`ifdef SUB_OVERFLOW_EN
    check({tag, ".ovf"}, 32'(ovf), 32'(got.ovf));
`endif
    check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_d"}, 32'(d), 32'(got.val[W-1:0]));
      check({tag, ".hold_bout"}, 32'(bout), 32'(got.val[W]));
      check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    if (hold != 0) tick();
    // With out_ready high from the start, the DONE->IDLE edge follows directly.
    if (hold == 0) tick();
    in_valid = 1'b0;
    check({tag, ".out_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("reset.in_ready", 32'(in_ready), 32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.d", 32'(d), 32'd0);
    check("reset.bout", 32'(bout), 32'd0);
`ifdef SUB_OVERFLOW_EN
    check("reset.ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("release.in_ready", 32'(in_ready), 32'd1);

    run_txn("basic",      16'h1234, 16'h0234, 1'b0, 0, 1'b0);
    run_txn("ripple",     16'h0000, 16'h0001, 1'b0, 0, 1'b0);
    run_txn("eq_bin",     16'h0005, 16'h0005, 1'b1, 0, 1'b0);
    run_txn("ovf_neg",    16'h8000, 16'h0001, 1'b0, 0, 1'b0);
    run_txn("ovf_pos",    16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
    run_txn("backpress",  16'hA5C3, 16'h3C5A, 1'b1, 10, 1'b0);
    run_txn("ignored_in", 16'h4321, 16'h1234, 1'b0, 3, 1'b1);

    // Reset mid-operation: accept at E0, rst sampled at E2.
    a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1;
    tick();          // E0
    in_valid = 1'b0;
    tick();          // E1
    rst = 1'b1;
    tick();          // E2
    rst = 1'b0;
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.d", 32'(d), 32'd0);
    check("midrst.bout", 32'(bout), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst.no_pulse", 32'(seen), 32'd0);
    run_txn("after_rst", 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
